// File: rtl/encaps_cu_pkg.sv
// Shared types and default sizing for the NTRU-HRSS encapsulation sequencer.
package encaps_cu_pkg;

    typedef enum logic [3:0] {
        IDLE,
        UNPACK,
        PREP,
        SAMPLE,
        ABSORB,
        PERM,
        BLKEND,
        ANSWER,
        DONE
    } cu_state_t;

    localparam int N_COEF_DEF     = 700;
    localparam int PACK_GROUP_DEF = 5;
    localparam int HASH_BYTES_DEF = 136;

    localparam int COEF_W  = 10;
    localparam int GROUP_W = 3;
    localparam int BYTE_W  = 8;

    // True when a packed byte count closes a SHA3 rate block.
    function automatic logic block_full(input logic [BYTE_W-1:0] b, input int hb);
        return (int'(b) % hb) == 0;
    endfunction

endpackage

// File: rtl/encaps_control_unit_if.sv
// Handshake and strobe bundle between the encapsulation sequencer and its datapath.
interface encaps_control_unit_if;

    logic       up_rq0_done;
    logic       hash_fin;
    logic       ovr_rst2;
    logic       halt_n;
    logic       sipo_u_clk;
    logic       sipo_t1_clk;
    logic       sipo_t2_clk;
    logic       sipo_p_clk;
    logic       sipo_p_stop;
    logic       p3_rst;
    logic [1:0] p3_count;
    logic       hash_rst1;
    logic       hash_rst2;
    logic       hash_sp;
    logic       hash_ans;
    logic       hash_keccak;
    logic       hash_clk;
    logic       enc_rst;
    logic       lift_en;

    modport master (
        input  up_rq0_done, hash_fin,
        output ovr_rst2, halt_n, sipo_u_clk, sipo_t1_clk, sipo_t2_clk,
               sipo_p_clk, sipo_p_stop, p3_rst, p3_count,
               hash_rst1, hash_rst2, hash_sp, hash_ans, hash_keccak, hash_clk,
               enc_rst, lift_en
    );

    modport slave (
        output up_rq0_done, hash_fin,
        input  ovr_rst2, halt_n, sipo_u_clk, sipo_t1_clk, sipo_t2_clk,
               sipo_p_clk, sipo_p_stop, p3_rst, p3_count,
               hash_rst1, hash_rst2, hash_sp, hash_ans, hash_keccak, hash_clk,
               enc_rst, lift_en
    );

endinterface

// File: rtl/encaps_control_unit_cu_toggle.sv
// Enable-gated one-bit toggler: square strobe while enabled, forced low otherwise.
module cu_toggle (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= en ? ~q : 1'b0;
        end
    end

endmodule

// File: rtl/encaps_control_unit.sv
// Sequencer for NTRU-HRSS encapsulation: unpack, sample/multiply/lift, pack_s3, SHA3 absorb/permute, key release.
module encaps_control_unit
    import encaps_cu_pkg::*;
#(
    parameter int N_COEF     = N_COEF_DEF,
    parameter int PACK_GROUP = PACK_GROUP_DEF,
    parameter int HASH_BYTES = HASH_BYTES_DEF
) (
    input  logic                  clk,
    input  logic                  ovr_rst1,
    encaps_control_unit_if.master bus
);

    cu_state_t          state;
    logic [COEF_W-1:0]  coef;
    logic [GROUP_W-1:0] group;
    logic [BYTE_W-1:0]  byte_cnt;
    logic               stop_q;
    logic               last_q;

    logic       ovr_rst2_q;
    logic       halt_n_q;
    logic       t2_q;
    logic       p_clk_q;
    logic       p_stop_q;
    logic       p3_rst_q;
    logic [1:0] p3_count_q;
    logic       hash_rst1_q;
    logic       hash_rst2_q;
    logic       hash_sp_q;
    logic       hash_ans_q;
    logic       keccak_q;
    logic       enc_rst_q;
    logic       lift_en_q;

    logic u_q;
    logic t1_q;
    logic h_q;

    logic [COEF_W-1:0] coef_inc;
    logic [BYTE_W-1:0] byte_nx;
    logic              coef_last;
    logic              grp_last;
    logic              phase_b;
    logic              blk_end;
    logic              u_en;
    logic              t1_en;
    logic              h_en;

    // In SAMPLE, t1_q high marks cycle A of a coefficient and low marks cycle B.
    always_comb begin
        coef_inc  = coef + 1'b1;
        byte_nx   = byte_cnt + 1'b1;
        coef_last = (coef == COEF_W'(N_COEF - 1));
        grp_last  = (group == GROUP_W'(PACK_GROUP - 1));
        phase_b   = (state == SAMPLE) && !stop_q && !t1_q;
        blk_end   = phase_b && (coef_last || (grp_last && block_full(byte_nx, HASH_BYTES)));
        u_en      = (state == IDLE) || ((state == UNPACK) && !bus.up_rq0_done);
        t1_en     = (state == PREP)
                 || ((state == BLKEND) && !last_q)
                 || ((state == SAMPLE) && !stop_q && !blk_end);
        h_en      = (state == PERM) && !bus.hash_fin;
    end

    cu_toggle u_tog_unpack (.clk(clk), .rst(ovr_rst1), .en(u_en),  .q(u_q));
    cu_toggle u_tog_coef   (.clk(clk), .rst(ovr_rst1), .en(t1_en), .q(t1_q));
    cu_toggle u_tog_hash   (.clk(clk), .rst(ovr_rst1), .en(h_en),  .q(h_q));

    always_ff @(posedge clk or posedge ovr_rst1) begin
        if (ovr_rst1) begin
            state       <= IDLE;
            coef        <= '0;
            group       <= '0;
            byte_cnt    <= '0;
            stop_q      <= 1'b0;
            last_q      <= 1'b0;
            ovr_rst2_q  <= 1'b1;
            halt_n_q    <= 1'b1;
            t2_q        <= 1'b0;
            p_clk_q     <= 1'b0;
            p_stop_q    <= 1'b0;
            p3_rst_q    <= 1'b1;
            p3_count_q  <= 2'd0;
            hash_rst1_q <= 1'b0;
            hash_rst2_q <= 1'b0;
            hash_sp_q   <= 1'b0;
            hash_ans_q  <= 1'b0;
            keccak_q    <= 1'b0;
            enc_rst_q   <= 1'b1;
            lift_en_q   <= 1'b0;
        end else begin
            p_clk_q     <= 1'b0;
            p_stop_q    <= 1'b0;
            hash_rst1_q <= 1'b0;
            hash_rst2_q <= 1'b0;
            hash_sp_q   <= 1'b0;
            hash_ans_q  <= 1'b0;

            case (state)
                IDLE: begin
                    ovr_rst2_q <= 1'b0;
                    state      <= UNPACK;
                end

                UNPACK: begin
                    if (bus.up_rq0_done) begin
                        hash_rst1_q <= 1'b1;
                        enc_rst_q   <= 1'b1;
                        p3_rst_q    <= 1'b1;
                        state       <= PREP;
                    end
                end

                PREP: begin
                    coef       <= '0;
                    group      <= '0;
                    byte_cnt   <= '0;
                    stop_q     <= 1'b0;
                    last_q     <= 1'b0;
                    p3_count_q <= 2'd0;
                    t2_q       <= 1'b0;
                    enc_rst_q  <= 1'b0;
                    p3_rst_q   <= 1'b0;
                    lift_en_q  <= 1'b1;
                    state      <= SAMPLE;
                end

                SAMPLE: begin
                    if (stop_q) begin
                        // Block-full cycle done: hand the rate block to the sponge.
                        stop_q    <= 1'b0;
                        lift_en_q <= 1'b0;
                        hash_sp_q <= 1'b1;
                        state     <= ABSORB;
                    end else if (t1_q) begin
                        p_clk_q <= grp_last;
                    end else begin
                        group <= grp_last ? '0 : group + 1'b1;
                        if (grp_last) begin
                            byte_cnt   <= byte_nx;
                            p3_count_q <= byte_nx[1:0];
                        end
                        if (coef_last) begin
                            last_q <= 1'b1;
                        end else begin
                            coef <= coef_inc;
                        end
                        // Parity holds across a block break; BLKEND reloads it.
                        if (blk_end) begin
                            stop_q   <= 1'b1;
                            p_stop_q <= 1'b1;
                        end else begin
                            t2_q <= coef_inc[0];
                        end
                    end
                end

                ABSORB: begin
                    keccak_q <= 1'b1;
                    state    <= PERM;
                end

                PERM: begin
                    if (bus.hash_fin) begin
                        keccak_q    <= 1'b0;
                        hash_rst2_q <= 1'b1;
                        p3_rst_q    <= 1'b1;
                        state       <= BLKEND;
                    end
                end

                BLKEND: begin
                    p3_rst_q <= 1'b0;
                    if (last_q) begin
                        hash_ans_q <= 1'b1;
                        state      <= ANSWER;
                    end else begin
                        lift_en_q <= 1'b1;
                        t2_q      <= coef[0];
                        state     <= SAMPLE;
                    end
                end

                ANSWER: begin
                    halt_n_q <= 1'b0;
                    t2_q     <= 1'b0;
                    state    <= DONE;
                end

                DONE: begin
                    state <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ovr_rst2    = ovr_rst2_q;
    assign bus.halt_n      = halt_n_q;
    assign bus.sipo_u_clk  = u_q;
    assign bus.sipo_t1_clk = t1_q;
    assign bus.sipo_t2_clk = t2_q;
    assign bus.sipo_p_clk  = p_clk_q;
    assign bus.sipo_p_stop = p_stop_q;
    assign bus.p3_rst      = p3_rst_q;
    assign bus.p3_count    = p3_count_q;
    assign bus.hash_rst1   = hash_rst1_q;
    assign bus.hash_rst2   = hash_rst2_q;
    assign bus.hash_sp     = hash_sp_q;
    assign bus.hash_ans    = hash_ans_q;
    assign bus.hash_keccak = keccak_q;
    assign bus.hash_clk    = h_q;
    assign bus.enc_rst     = enc_rst_q;
    assign bus.lift_en     = lift_en_q;

endmodule

// File: tb/tb_encaps_control_unit.sv
// Directed bench for encaps_control_unit: whole-run pulse tallies per table row plus reset/abort/done sequences.
module tb_encaps_control_unit;

    logic clk;
    logic rst;

    encaps_control_unit_if bus();

    encaps_control_unit dut (
        .clk      (clk),
        .ovr_rst1 (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unpack_len;
        int perm_pulses;
        bit noise;
        int exp_u;
        int exp_t1;
        int exp_t2;
        int exp_p;
        int exp_hclk;
        int exp_done_at;
    } row_t;

    // {ovr_rst2, halt_n, u, t1, t2, p, p_stop, p3_rst, p3_count, rst1, rst2, sp, ans, keccak, hclk, enc_rst, lift_en}
    localparam logic [17:0] RESET_VEC = 18'b11_00000_1_00_000000_1_0;
    localparam logic [17:0] DONE_VEC  = 18'b00_00000_0_00_000000_0_0;
    localparam int          NROWS     = 3;
    localparam int          BUDGET    = 3000;

    int n_cmp = 0;
    int n_bad = 0;

    int cur_u, cur_k;
    bit cur_noise;
    int cyc, uc, pp, done_at;
    int n_u, n_t1, n_t2, n_p, n_stop, n_h, n_sp, n_rst1, n_rst2, n_ans;
    int shape_err, p3_err, wraps;
    int stop_byte [2];
    logic pu, pt1, pt2, pp_clk, ph;
    logic [1:0] pp3;

    function automatic logic [17:0] outv();
        return {bus.ovr_rst2, bus.halt_n, bus.sipo_u_clk, bus.sipo_t1_clk, bus.sipo_t2_clk,
                bus.sipo_p_clk, bus.sipo_p_stop, bus.p3_rst, bus.p3_count,
                bus.hash_rst1, bus.hash_rst2, bus.hash_sp, bus.hash_ans, bus.hash_keccak,
                bus.hash_clk, bus.enc_rst, bus.lift_en};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One cycle: sample at the falling edge, tally, then answer like the datapath would.
    task automatic step();
        logic in_unpack;
        @(negedge clk);
        cyc++;
        if (bus.sipo_u_clk && !pu) n_u++;
        if (bus.sipo_t1_clk && !pt1) n_t1++;
        if (bus.sipo_t2_clk && !pt2) n_t2++;
        if (bus.sipo_p_clk && !pp_clk) n_p++;
        if (bus.hash_clk && !ph) begin
            n_h++;
            pp++;
        end
        if ((bus.sipo_u_clk && pu) || (bus.sipo_t1_clk && pt1) ||
            (bus.sipo_p_clk && pp_clk) || (bus.hash_clk && ph)) shape_err++;
        if (bus.sipo_p_stop) begin
            if (n_stop < 2) stop_byte[n_stop] = n_p;
            n_stop++;
        end
        if (bus.hash_sp) n_sp++;
        if (bus.hash_rst1) n_rst1++;
        if (bus.hash_rst2) n_rst2++;
        if (bus.hash_ans) n_ans++;
        if (bus.p3_count != pp3) begin
            if (bus.p3_count != 2'(pp3 + 2'd1)) p3_err++;
            if (pp3 == 2'd3 && bus.p3_count == 2'd0) wraps++;
            pp3 = bus.p3_count;
        end
        if (!bus.halt_n && done_at == 0) done_at = cyc;
        pu = bus.sipo_u_clk;
        pt1 = bus.sipo_t1_clk;
        pt2 = bus.sipo_t2_clk;
        pp_clk = bus.sipo_p_clk;
        ph = bus.hash_clk;

        if (bus.hash_keccak) begin
            bus.hash_fin = (pp >= cur_k);
        end else begin
            pp = 0;
            bus.hash_fin = cur_noise;
        end
        in_unpack = !bus.ovr_rst2 && bus.enc_rst && !bus.hash_rst1 && bus.halt_n;
        if (in_unpack) begin
            uc++;
            bus.up_rq0_done = (uc >= cur_u);
        end else begin
            bus.up_rq0_done = cur_noise;
        end
    endtask

    task automatic start_run(input int u, input int k, input bit noise);
        rst = 1'b1;
        cur_u = u;
        cur_k = k;
        cur_noise = noise;
        bus.up_rq0_done = noise;
        bus.hash_fin = noise;
        @(negedge clk);
        @(negedge clk);
        cyc = 0; uc = 0; pp = 0; done_at = 0;
        n_u = 0; n_t1 = 0; n_t2 = 0; n_p = 0; n_stop = 0; n_h = 0;
        n_sp = 0; n_rst1 = 0; n_rst2 = 0; n_ans = 0;
        shape_err = 0; p3_err = 0; wraps = 0;
        stop_byte[0] = 0;
        stop_byte[1] = 0;
        pu = 1'b0; pt1 = 1'b0; pt2 = 1'b0; pp_clk = 1'b0; ph = 1'b0;
        pp3 = 2'd0;
        rst = 1'b0;
    endtask

    row_t rows [NROWS];

    initial begin
        // Cycles to DONE, counted from the first falling edge after release: U + 2*perm_cycles + 1409.
        rows[0] = '{10, 24, 1'b0, 5, 700, 350, 140, 48, 1515};
        rows[1] = '{ 7,  0, 1'b1, 4, 700, 350, 140,  0, 1418};
        rows[2] = '{ 1,  3, 1'b1, 1, 700, 350, 140,  6, 1422};

        rst = 1'b1;
        bus.up_rq0_done = 1'b0;
        bus.hash_fin = 1'b0;
        cur_u = 0; cur_k = 0; cur_noise = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_v("reset_values", outv(), RESET_VEC);

        // Abort in the middle of the first permutation.
        start_run(10, 24, 1'b0);
        for (int c = 0; c < BUDGET && !(bus.hash_keccak && pp >= 5); c++) step();
        check("abort_reached_perm", (bus.hash_keccak && pp >= 5) ? 1 : 0, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_v("async_reset_midcycle", outv(), RESET_VEC);
        @(negedge clk);
        check_v("reset_held", outv(), RESET_VEC);

        for (int i = 0; i < NROWS; i++) begin
            start_run(rows[i].unpack_len, rows[i].perm_pulses, rows[i].noise);
            for (int c = 0; c < BUDGET && done_at == 0; c++) step();
            repeat (3) step();
            check($sformatf("row%0d_u_pulses", i), n_u, rows[i].exp_u);
            check($sformatf("row%0d_t1_pulses", i), n_t1, rows[i].exp_t1);
            check($sformatf("row%0d_t2_periods", i), n_t2, rows[i].exp_t2);
            check($sformatf("row%0d_p_pulses", i), n_p, rows[i].exp_p);
            check($sformatf("row%0d_hash_clk", i), n_h, rows[i].exp_hclk);
            check($sformatf("row%0d_done_cycle", i), done_at, rows[i].exp_done_at);
            check($sformatf("row%0d_p_stop_cycles", i), n_stop, 2);
            check($sformatf("row%0d_stop1_byte", i), stop_byte[0], 136);
            check($sformatf("row%0d_stop2_byte", i), stop_byte[1], 140);
            check($sformatf("row%0d_hash_sp", i), n_sp, 2);
            check($sformatf("row%0d_hash_rst1", i), n_rst1, 1);
            check($sformatf("row%0d_hash_rst2", i), n_rst2, 2);
            check($sformatf("row%0d_hash_ans", i), n_ans, 1);
            check($sformatf("row%0d_p3_wraps", i), wraps, 35);
            check($sformatf("row%0d_p3_steps", i), p3_err, 0);
            check($sformatf("row%0d_strobe_shape", i), shape_err, 0);
            check_v($sformatf("row%0d_done_outputs", i), outv(), DONE_VEC);
        end

        // Late input activity in DONE must not disturb anything.
        for (int j = 0; j < 6; j++) begin
            bus.up_rq0_done = j[0];
            bus.hash_fin = ~j[0];
            @(negedge clk);
            check_v($sformatf("done_steady%0d", j), outv(), DONE_VEC);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
